mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Multi-cycle RV64M execute unit, directly downstream of the instruction decoder.
- Consumes the decoder's 5-bit alu_ctrl codes for mul, mulw, divw and remw, plus the two register operands.
- Produces a 64-bit writeback result through a valid/ready handshake, so the core stalls until the result arrives.
- Multiplication is shift-add, radix-2. Division is restoring, radix-2.

Parameters:
- XLEN, 64, operand/result width (only 64 is supported).
- CNT_W, 7, iteration counter width (must hold 64).

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept an operation
- alu_ctrl  in  5  decoder op code: 10001 remw, 10010 divw, 10011 mulw, 10100 mul
- src1  in  64  rs1 value
- src2  in  64  rs2 value
- flush  in  1  abort any operation in flight
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  64  writeback value
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, busy=0, counter=0. Reset mid-operation discards the operation; no result is ever produced for it.
- States: IDLE, CALC, DONE.
  - in_ready = (state==IDLE).
  - Acceptance = in_valid & in_ready & alu_ctrl ∈ {10001,10010,10011,10100}.
  - Any other alu_ctrl with in_valid: no state change, no result.
- IDLE→CALC on acceptance: operands latched, counter cleared. Exception: divw/remw special cases go IDLE→DONE directly.
- Special cases (32-bit divides):
  - Divide by zero: divw result = 0xFFFF_FFFF_FFFF_FFFF; remw result = sext(src1[31:0]).
  - Overflow (src1[31:0]=0x8000_0000, src2[31:0]=0xFFFF_FFFF): divw result = 0xFFFF_FFFF_8000_0000; remw result = 0.
- Iteration counts N: mul 64; mulw 32; divw/remw 32.
  - Each CALC cycle performs one iteration and increments the counter.
  - CALC→DONE on the cycle the counter reaches N-1.
- Latency: operation accepted at edge T → out_valid high after edge T+N+1. Special cases → out_valid after edge T+1.
- mul: low 64 bits of src1*src2. Signedness is irrelevant for the low half.
- mulw: src1[31:0]*src2[31:0]; result = sext(product[31:0]).
- divw/remw:
  - Operate on the low 32 bits as signed values; upper bits of src1/src2 are ignored.
  - Divide magnitudes unsigned, then fix signs: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - result = sext(32-bit quotient or remainder).
- DONE:
  - out_valid=1; result is held stable while out_ready=0.
  - DONE→IDLE on out_ready. in_ready rises the following cycle; there is no same-cycle re-accept.
- flush: from any state, at the next edge go to IDLE with out_valid=0. If flush and in_valid are asserted in the same cycle, flush wins and nothing is accepted.
- Simultaneous rst and flush: rst behaviour.
- result register updates only on the transition into DONE and is otherwise held.

Test Plan:
- mul, src1=0x7, src2=0xFFFF_FFFF_FFFF_FFFD, accepted at T → out_valid at T+65, result=0xFFFF_FFFF_FFFF_FFEB; in_ready=0 throughout T+1..T+65.
- mulw, src1=0x4000_0000, src2=0x2 → result=0xFFFF_FFFF_8000_0000 at T+33. Also src1=0x1234_0001_0000_0000 (low half 0), src2=5 → result 0.
- divw, src1=0xFFFF_FFF9 (-7), src2=2 → 0xFFFF_FFFF_FFFF_FFFD at T+33. remw with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- Special cases:
  - divw 5/0 → 0xFFFF_FFFF_FFFF_FFFF at T+1; remw 5/0 → 0x5 at T+1.
  - divw 0x8000_0000/0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000; remw with the same operands → 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result and out_valid stable, in_ready=0. Raise out_ready → next cycle out_valid=0, in_ready=1.
- Abort: assert flush at CALC cycle 10 of mul → out_valid never rises, in_ready=1 next cycle. Repeat with rst → identical behaviour. Offer alu_ctrl=00001 with in_valid=1 → busy stays 0.

Source files
------------

// File: rtl/mdu_iter.sv
// Purpose : iterative RV64M execute unit for mul/mulw (shift-add) and divw/remw (restoring), radix-2.
// Latency : mul 65 cycles, mulw/divw/remw 33 cycles, divw/remw divide-by-zero/overflow 1 cycle after accept.
// Backpr. : result and out_valid held in DONE until out_ready; in_ready low from accept until one cycle after release.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready, alu_ctrl      operation offer (5-bit decoder code), src1/src2 operands
//   flush                            abort any operation in flight (rst has priority)
//   out_valid/out_ready, result      64-bit writeback handshake
//   busy                             unit is not idle
module mdu_iter #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_ctrl,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [4:0] OP_REMW = 5'b10001;
    localparam logic [4:0] OP_DIVW = 5'b10010;
    localparam logic [4:0] OP_MULW = 5'b10011;
    localparam logic [4:0] OP_MUL  = 5'b10100;

    localparam logic [CNT_W-1:0] LAST_MUL  = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(31);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CNT_W-1:0] cnt;
    logic [4:0]      op_r;
    // mul: a_reg = shifted multiplicand, b_reg = shifted multiplier, acc = partial product
    // div: a_reg[31:0] = dividend shifting out / quotient shifting in,
    //      b_reg[31:0] = divisor magnitude, acc[31:0] = partial remainder
    logic [XLEN-1:0] a_reg;
    logic [XLEN-1:0] b_reg;
    logic [XLEN-1:0] acc;
    // First CALC cycle only checks divide corner cases and takes operand magnitudes.
    logic            setup;
    logic            neg_q;
    logic            neg_r;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    logic op_ok;
    logic is_div;
    assign op_ok  = (alu_ctrl == OP_REMW) || (alu_ctrl == OP_DIVW) ||
                    (alu_ctrl == OP_MULW) || (alu_ctrl == OP_MUL);
    assign is_div = (op_r == OP_DIVW) || (op_r == OP_REMW);

    // One shift-add step.
    logic [XLEN-1:0] mul_acc_nxt;
    assign mul_acc_nxt = acc + (b_reg[0] ? a_reg : '0);

    // One restoring-divide step. The shifted partial remainder is below
    // 2*divisor, so bit 32 of the 33-bit difference is a clean borrow flag.
    logic [32:0] div_shift;
    logic [32:0] div_trial;
    logic        div_ge;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;
    assign div_shift = {acc[31:0], a_reg[31]};
    assign div_trial = div_shift - {1'b0, b_reg[31:0]};
    assign div_ge    = ~div_trial[32];
    assign rem_nxt   = div_ge ? div_trial[31:0] : div_shift[31:0];
    assign quo_nxt   = {a_reg[30:0], div_ge};

    // Sign fix-up: quotient negative when signs differ, remainder follows dividend.
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    assign q_fix = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
    assign r_fix = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;

    logic [XLEN-1:0]  final_res;
    logic [CNT_W-1:0] last_cnt;
    always_comb begin
        final_res = mul_acc_nxt;
        case (op_r)
            OP_MULW: final_res = sext32(mul_acc_nxt[31:0]);
            OP_DIVW: final_res = sext32(q_fix);
            OP_REMW: final_res = sext32(r_fix);
            default: final_res = mul_acc_nxt;
        endcase
        last_cnt = (op_r == OP_MUL) ? LAST_MUL : LAST_WORD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            op_r      <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            setup     <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && op_ok) begin
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        op_r     <= alu_ctrl;
                        a_reg    <= src1;
                        b_reg    <= src2;
                        acc      <= '0;
                        cnt      <= '0;
                        setup    <= 1'b1;
                    end
                end

                CALC: begin
                    if (setup) begin
                        setup <= 1'b0;
                        if (is_div) begin
                            if (b_reg[31:0] == 32'd0) begin
                                result    <= (op_r == OP_DIVW) ? '1 : sext32(a_reg[31:0]);
                                state     <= DONE;
                                out_valid <= 1'b1;
                            end else if (a_reg[31:0] == 32'h8000_0000 &&
                                         b_reg[31:0] == 32'hFFFF_FFFF) begin
                                result    <= (op_r == OP_DIVW) ? sext32(32'h8000_0000) : '0;
                                state     <= DONE;
                                out_valid <= 1'b1;
                            end else begin
                                a_reg <= {{(XLEN-32){1'b0}}, abs32(a_reg[31:0])};
                                b_reg <= {{(XLEN-32){1'b0}}, abs32(b_reg[31:0])};
                                neg_q <= a_reg[31] ^ b_reg[31];
                                neg_r <= a_reg[31];
                            end
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (is_div) begin
                            acc   <= {{(XLEN-32){1'b0}}, rem_nxt};
                            a_reg <= {{(XLEN-32){1'b0}}, quo_nxt};
                        end else begin
                            acc   <= mul_acc_nxt;
                            a_reg <= a_reg << 1;
                            b_reg <= b_reg >> 1;
                        end
                        if (cnt == last_cnt) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= final_res;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Purpose : directed self-checking bench for mdu_iter.
// Latency : counts edges from the accepting edge to the first sample with out_valid high.
// Backpr. : holds out_ready low while waiting, then releases it for one cycle per operation.
module tb_mdu_iter;

    localparam logic [4:0] OP_REMW = 5'b10001;
    localparam logic [4:0] OP_DIVW = 5'b10010;
    localparam logic [4:0] OP_MULW = 5'b10011;
    localparam logic [4:0] OP_MUL  = 5'b10100;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  alu_ctrl;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mdu_iter dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_ctrl (alu_ctrl),
        .src1     (src1),
        .src2     (src2),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .busy     (busy)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
        in_valid = 1'b1;
        alu_ctrl = op;
        src1     = a;
        src2     = b;
        tick();
        in_valid = 1'b0;
        alu_ctrl = 5'b0;
        src1     = '0;
        src2     = '0;
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] a,
                          input logic [63:0] b, input int exp_lat, input logic [63:0] exp_res,
                          input int hold);
        int          lat;
        logic        rdy_seen;
        logic        unstable;
        logic [63:0] r0;
        offer(op, a, b);
        lat      = -1;
        rdy_seen = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (in_ready) rdy_seen = 1'b1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_in_ready_low"}, 64'(rdy_seen), 64'd0);
        chk({tag, "_result"}, result, exp_res);
        if (hold > 0) begin
            r0       = result;
            unstable = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (result !== r0 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
                    unstable = 1'b1;
            end
            chk({tag, "_hold_stable"}, 64'(unstable), 64'd0);
            chk({tag, "_hold_result"}, result, exp_res);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_release"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_ctrl  = 5'b0;
        src1      = '0;
        src2      = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_state", {result[59:0], out_valid, in_ready, busy, 1'b0}, 64'b0100);
        chk("reset_result", result, 64'd0);

        // Multiplication
        run_op("mul_7_m3", OP_MUL, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD, 65,
               64'hFFFF_FFFF_FFFF_FFEB, 10);
        run_op("mul_wide", OP_MUL, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 65,
               64'h0000_0002_0000_0001, 0);
        run_op("mulw_ovf", OP_MULW, 64'h4000_0000, 64'h2, 33, 64'hFFFF_FFFF_8000_0000, 0);
        run_op("mulw_lowzero", OP_MULW, 64'h1234_0001_0000_0000, 64'h5, 33, 64'h0, 0);
        run_op("mulw_neg", OP_MULW, 64'hFFFF_FFFF, 64'h3, 33, 64'hFFFF_FFFF_FFFF_FFFD, 0);

        // Division
        run_op("divw_m7_2", OP_DIVW, 64'hFFFF_FFF9, 64'h2, 33, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("remw_m7_2", OP_REMW, 64'hFFFF_FFF9, 64'h2, 33, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("divw_100_7", OP_DIVW, 64'h64, 64'hABCD_0000_0000_0007, 33, 64'hE, 0);
        run_op("remw_100_m7", OP_REMW, 64'h64, 64'hFFFF_FFF9, 33, 64'h2, 0);
        run_op("remw_m100_7", OP_REMW, 64'h5555_5555_FFFF_FF9C, 64'h7, 33,
               64'hFFFF_FFFF_FFFF_FFFE, 0);

        // Divide corner cases
        run_op("divw_by0", OP_DIVW, 64'h5, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("remw_by0", OP_REMW, 64'h5, 64'hFFFF_0000_0000_0000, 1, 64'h5, 0);
        run_op("divw_ovf", OP_DIVW, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0000, 3);
        run_op("remw_ovf", OP_REMW, 64'h8000_0000, 64'hFFFF_FFFF, 1, 64'h0, 0);

        // Flush mid-multiply
        offer(OP_MUL, 64'h3, 64'h5);
        repeat (10) tick();
        chk("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", {61'd0, out_valid, in_ready, busy}, 64'b010);
        seen = 1'b0;
        repeat (70) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        chk("flush_no_result", 64'(seen), 64'd0);

        // Flush wins over a simultaneous offer
        in_valid = 1'b1;
        alu_ctrl = OP_MUL;
        src1     = 64'h2;
        src2     = 64'h2;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        tick();
        chk("flush_vs_offer", {61'd0, out_valid, in_ready, busy}, 64'b010);

        // Reset mid-multiply
        offer(OP_MUL, 64'h3, 64'h5);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_idle", {61'd0, out_valid, in_ready, busy}, 64'b010);
        chk("rst_result_cleared", result, 64'd0);
        seen = 1'b0;
        repeat (70) begin
            tick();
            if (out_valid || busy) seen = 1'b1;
        end
        chk("rst_no_result", 64'(seen), 64'd0);

        // Unsupported opcode is ignored
        in_valid = 1'b1;
        alu_ctrl = 5'b00001;
        src1     = 64'h9;
        src2     = 64'h9;
        seen     = 1'b0;
        repeat (4) begin
            tick();
            if (busy || !in_ready) seen = 1'b1;
        end
        in_valid = 1'b0;
        chk("bad_op_ignored", 64'(seen), 64'd0);

        // Unit still works afterwards
        run_op("mul_after", OP_MUL, 64'd12, 64'd11, 65, 64'd132, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
